// File: rtl/bg_tile_fetch_sched.sv
// ---------------------------------------------------------------------------
// bg_tile_fetch_sched
// Per-scanline sequencer for background tile fetches. For every enabled BG
// layer (lowest first) and every tile column it issues one screen-entry read,
// then the char-data reads for one 8-pixel tile row on a shared VRAM port.
//
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   line_start, abort   start a line (IDLE only) / cancel the current line
//   bg_enable           per-BG enable, latched at an accepted line_start
//   bg_palettemode      per-BG colour mode (0=16-colour, 1=256-colour)
//   vram_req/kind       read request and its type (0=screen, 1=char)
//   vram_ack/rdata      request accepted, read data valid the same cycle
//   bg_sel, tile_idx    BG layer and tile column currently being fetched
//   screendata          latched screen entry for the char address lookup
//   char_x, palettemode pixel x of the current char beat, mode of bg_sel
//   pix_*               registered char-data beat with its tags
//   busy, line_done     not idle / one-cycle end-of-line pulse
// ---------------------------------------------------------------------------
module bg_tile_fetch_sched #(
    parameter int TILES_PER_LINE = 32,
    parameter int TW             = 6
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          line_start,
    input  logic          abort,
    input  logic [3:0]    bg_enable,
    input  logic [3:0]    bg_palettemode,
    output logic          vram_req,
    output logic          vram_kind,
    input  logic          vram_ack,
    input  logic [15:0]   vram_rdata,
    output logic [1:0]    bg_sel,
    output logic [TW-1:0] tile_idx,
    output logic [11:0]   screendata,
    output logic [2:0]    char_x,
    output logic          palettemode,
    output logic          pix_valid,
    output logic [15:0]   pix_data,
    output logic [1:0]    pix_bg,
    output logic [TW-1:0] pix_tile,
    output logic [1:0]    pix_beat,
    output logic          busy,
    output logic          line_done
);

    typedef enum logic [1:0] {IDLE, SCREEN, CHAR, DONE} state_t;

    state_t        state_q, state_d;
    logic [3:0]    en_q, en_d;
    logic [3:0]    mode_q, mode_d;
    logic [1:0]    bg_q, bg_d;
    logic [TW-1:0] tile_q, tile_d;
    logic [1:0]    beat_q, beat_d;
    logic [11:0]   screen_q, screen_d;
    logic          pixValid_q, pixValid_d;
    logic [15:0]   pixData_q, pixData_d;
    logic [1:0]    pixBg_q, pixBg_d;
    logic [TW-1:0] pixTile_q, pixTile_d;
    logic [1:0]    pixBeat_q, pixBeat_d;

    logic [2:0]    firstBg;
    logic [2:0]    nextBg;
    logic          curMode;
    logic [1:0]    lastBeat;

    // Lowest set bit of mask at or above 'from'; returns 4 when none is left.
    function automatic logic [2:0] findBg(input logic [3:0] mask, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (i[2:0] >= from)) r = i[2:0];
        end
        return r;
    endfunction

    assign curMode  = mode_q[bg_q];
    assign lastBeat = curMode ? 2'd3 : 2'd1;
    assign firstBg  = findBg(bg_enable, 3'd0);
    assign nextBg   = findBg(en_q, {1'b0, bg_q} + 3'd1);

    // Request and status outputs are decoded straight from the state so that
    // an abort drops the request in the very cycle it is asserted.
    assign vram_req    = ((state_q == SCREEN) || (state_q == CHAR)) && !abort;
    assign vram_kind   = (state_q == CHAR);
    assign bg_sel      = bg_q;
    assign tile_idx    = tile_q;
    assign screendata  = screen_q;
    assign palettemode = curMode;
    assign char_x      = (state_q != CHAR) ? 3'd0 :
                         curMode ? {beat_q, 1'b0} : {beat_q[0], 2'b00};
    assign busy        = (state_q != IDLE);
    assign line_done   = (state_q == DONE) && !abort;
    assign pix_valid   = pixValid_q;
    assign pix_data    = pixData_q;
    assign pix_bg      = pixBg_q;
    assign pix_tile    = pixTile_q;
    assign pix_beat    = pixBeat_q;

    // Next-state logic: walks BG layers lowest-first, tiles left to right,
    // and beats within a tile row. Every field only moves on an ack, which
    // keeps the request stable while the arbiter stalls. Abort overrides all,
    // so an ack landing in the abort cycle is simply discarded.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        bg_d       = bg_q;
        tile_d     = tile_q;
        beat_d     = beat_q;
        screen_d   = screen_q;
        pixValid_d = 1'b0;
        pixData_d  = pixData_q;
        pixBg_d    = pixBg_q;
        pixTile_d  = pixTile_q;
        pixBeat_d  = pixBeat_q;
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (line_start) begin
                        if (bg_enable != 4'd0) begin
                            en_d    = bg_enable;
                            mode_d  = bg_palettemode;
                            bg_d    = firstBg[1:0];
                            tile_d  = '0;
                            state_d = SCREEN;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
                SCREEN: begin
                    if (vram_ack) begin
                        screen_d = vram_rdata[11:0];
                        beat_d   = 2'd0;
                        state_d  = CHAR;
                    end
                end
                CHAR: begin
                    if (vram_ack) begin
                        pixValid_d = 1'b1;
                        pixData_d  = vram_rdata;
                        pixBg_d    = bg_q;
                        pixTile_d  = tile_q;
                        pixBeat_d  = beat_q;
                        if (beat_q != lastBeat) begin
                            beat_d = beat_q + 2'd1;
                        end else if (tile_q != TW'(TILES_PER_LINE - 1)) begin
                            tile_d  = tile_q + 1'b1;
                            state_d = SCREEN;
                        end else if (nextBg[2]) begin
                            state_d = DONE;
                        end else begin
                            bg_d    = nextBg[1:0];
                            tile_d  = '0;
                            state_d = SCREEN;
                        end
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State register; reset clears every latched field and the pix outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            en_q       <= '0;
            mode_q     <= '0;
            bg_q       <= '0;
            tile_q     <= '0;
            beat_q     <= '0;
            screen_q   <= '0;
            pixValid_q <= 1'b0;
            pixData_q  <= '0;
            pixBg_q    <= '0;
            pixTile_q  <= '0;
            pixBeat_q  <= '0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            bg_q       <= bg_d;
            tile_q     <= tile_d;
            beat_q     <= beat_d;
            screen_q   <= screen_d;
            pixValid_q <= pixValid_d;
            pixData_q  <= pixData_d;
            pixBg_q    <= pixBg_d;
            pixTile_q  <= pixTile_d;
            pixBeat_q  <= pixBeat_d;
        end
    end

endmodule

// File: doc/bg_tile_fetch_sched.md
Name: bg_tile_fetch_sched

Overview:
Per-scanline sequencer for background tile fetches. For each enabled BG layer and each tile column, it issues one screen-entry read, then the char-data reads for one 8-pixel tile row on a shared VRAM read port. It latches the screen entry and drives the x phase that feeds the char address lookup datapath. It sits between the BG control registers / line timing and the VRAM arbiter.

Parameters:
TILES_PER_LINE, 32, tile columns fetched per BG per line (2..64)
TW, 6, tile index width; must satisfy 2**TW >= TILES_PER_LINE

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
line_start  in  1  one-cycle pulse to begin a line's fetches
abort  in  1  synchronous cancel of current line
bg_enable  in  4  per-BG enable, sampled at accepted line_start
bg_palettemode  in  4  per-BG colour mode (0=16-colour, 1=256-colour), sampled at accepted line_start
vram_req  out  1  read request to VRAM arbiter
vram_kind  out  1  0=screen-entry read, 1=char-data read
vram_ack  in  1  request accepted; vram_rdata valid this cycle
vram_rdata  in  16  read data
bg_sel  out  2  BG currently being fetched
tile_idx  out  TW  tile column currently being fetched
screendata  out  12  latched screen entry, drives char address lookup
char_x  out  3  pixel x within tile row for the current char beat
palettemode  out  1  latched mode of bg_sel
pix_valid  out  1  one-cycle pulse: pix_data holds a char-data beat
pix_data  out  16  char-data beat
pix_bg  out  2  BG tag for pix_data
pix_tile  out  TW  tile tag for pix_data
pix_beat  out  2  beat index within tile row
busy  out  1  high in any state except IDLE
line_done  out  1  one-cycle pulse when all enabled BGs finish

Behaviour:
- States: IDLE, SCREEN, CHAR, DONE. Reset: state IDLE. All outputs 0, including screendata, pix_* and latched enables/modes.
- IDLE: line_start with bg_enable!=0 -> latch enables/modes. bg_sel=lowest enabled BG, tile_idx=0, next state SCREEN.
- IDLE: line_start with bg_enable==0 -> DONE.
- line_start outside IDLE is ignored.
- SCREEN: vram_req=1, vram_kind=0. On vram_ack: screendata<=vram_rdata[11:0], beat<=0, next state CHAR.
- CHAR: vram_req=1, vram_kind=1. char_x=beat*2 in 256-colour mode, beat*4 in 16-colour mode.
- CHAR, on vram_ack: next cycle pix_valid=1 with pix_data=vram_rdata and pix_bg/pix_tile/pix_beat equal to the acked beat's values.
- Last beat is 1 in 16-colour mode and 3 in 256-colour mode. A non-last ack increments beat and stays in CHAR.
- Last-beat ack with tile_idx<TILES_PER_LINE-1: tile_idx+1, next state SCREEN.
- Last-beat ack with tile_idx==TILES_PER_LINE-1: bg_sel=next higher enabled BG, tile_idx=0, next state SCREEN. If no higher enabled BG remains, next state DONE.
- bg_sel/tile_idx/vram_kind/char_x/screendata are stable while vram_req=1 and vram_ack=0. vram_req is never dropped without an ack, except on abort or reset.
- DONE: line_done=1 for exactly one cycle -> IDLE. busy is 0 in IDLE only.
- abort: any state -> IDLE next cycle. vram_req=0 that cycle; no line_done. An ack coinciding with abort is discarded: no pix_valid, no screendata update. abort beats line_start in the same cycle.
- Async reset mid-fetch: immediate IDLE, vram_req=0, pix_valid=0.
- Throughput: with vram_ack tied high, one VRAM access per cycle. A tile costs 3 cycles (16-colour) or 5 cycles (256-colour).

Test Plan:
- TILES_PER_LINE=4, bg_enable=0001, modes=0, ack tied 1 -> 12 requests, kinds S,C,C repeating, char_x 0,4; 8 pix_valid; line_done at cycle 13 after start.
- bg_enable=1010, bg_palettemode=1000 -> BG1 tiles use beats 0-1, then BG3 beats 0-3 with char_x 0,2,4,6; BG0/BG2 never selected.
- Random ack stalls (0-5 cycles) -> request fields stable until ack; screendata equals rdata[11:0] of the last screen ack; pix tags match.
- bg_enable=0000 -> line_done one cycle after line_start, no vram_req.
- abort asserted on a CHAR ack mid-line -> no pix_valid for that beat, IDLE next cycle, no line_done; a following line_start restarts at tile 0.
- line_start while busy -> ignored; async reset mid-SCREEN -> vram_req, busy, pix_valid and screendata all 0 immediately.
